// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: branch/stall control in, program memory port, IF/ID outputs.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  stall;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [31:0]           pmem_rdata;
    logic [31:0]           instruction_out;
    logic [ADDR_WIDTH-1:0] return_addr_out;
    logic                  take_branch_addr_out;
    logic                  fetch_valid;

    // Fetch stage drives the memory address and the IF/ID register inputs.
    modport master (
        input  stall, branch_taken, branch_target, pmem_rdata,
        output pmem_addr, instruction_out, return_addr_out,
               take_branch_addr_out, fetch_valid
    );

    // Surrounding pipeline / memory side.
    modport slave (
        output stall, branch_taken, branch_target, pmem_rdata,
        input  pmem_addr, instruction_out, return_addr_out,
               take_branch_addr_out, fetch_valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, synchronous program memory
// addressing, stall by re-read and branch by squash-and-redirect.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH   = 14,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]           NOP_WORD     = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                nreset,
    instruction_fetch_if.master fif
);
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Address increment wraps modulo 2^ADDR_WIDTH.
    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1);
    endfunction

    addr_t pc_p0;             // next sequential issue address
    addr_t inflight_addr_p1;  // address issued last cycle (word now on pmem_rdata)
    logic  vld_p1;            // a real word is in flight (RUN) vs FILL
    logic  from_branch_p1;    // in-flight word was the first fetched from a target
    logic  hold;
    logic  present_vld;

    // ---- Stage 0: issue address to program memory ----
    // Redirect beats re-read, re-read beats sequential advance.
    always_comb begin
        hold = fif.stall & vld_p1;
        if (fif.branch_taken) begin
            fif.pmem_addr = fif.branch_target;
        end else if (hold) begin
            fif.pmem_addr = inflight_addr_p1;
        end else begin
            fif.pmem_addr = pc_p0;
        end
    end

    // Advance, hold or redirect the fetch registers each cycle.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            pc_p0            <= RESET_VECTOR;
            inflight_addr_p1 <= '0;
            vld_p1           <= 1'b0;
            from_branch_p1   <= 1'b0;
        end else if (fif.branch_taken) begin
            pc_p0            <= addr_inc(fif.branch_target);
            inflight_addr_p1 <= fif.branch_target;
            vld_p1           <= 1'b1;
            from_branch_p1   <= 1'b1;
        end else if (!hold) begin
            pc_p0            <= addr_inc(pc_p0);
            inflight_addr_p1 <= pc_p0;
            vld_p1           <= 1'b1;
            from_branch_p1   <= 1'b0;
        end
    end

    // ---- Stage 1: present returned word to IF/ID ----
    // A redirect squashes the wrong-path word in the same cycle.
    always_comb begin
        present_vld              = vld_p1 & ~fif.branch_taken;
        fif.fetch_valid          = present_vld;
        fif.instruction_out      = present_vld ? fif.pmem_rdata : NOP_WORD;
        fif.return_addr_out      = present_vld ? addr_inc(inflight_addr_p1) : '0;
        fif.take_branch_addr_out = present_vld & from_branch_p1;
    end
endmodule
